// File: rtl/vx_tex_bilerp.sv
// Bilinear texel filter: blends a 2x2 A8R8G8B8 quad with U/V weights through a
// 2-stage valid/ready pipeline. Point mode forwards texel 0 unchanged.
module vx_tex_bilerp #(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_filter,
    input  logic [3:0][31:0]      req_texels,
    input  logic [FRAC_BITS-1:0]  req_blend_u,
    input  logic [FRAC_BITS-1:0]  req_blend_v,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_texel,
    output logic [TAG_WIDTH-1:0]  rsp_tag
);

    localparam int unsigned CH_W   = 8;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned TEX_W  = CH_W * NUM_CH;
    localparam int unsigned LW     = CH_W + FRAC_BITS + 1;
    localparam int unsigned ONE    = 1 << FRAC_BITS;
    localparam int unsigned HALF   = 1 << (FRAC_BITS - 1);

    // Rounded unsigned blend; the weights sum to 2^F so the result never leaves [a,b].
    function automatic logic [CH_W-1:0] lerp(
        input logic [CH_W-1:0]      a,
        input logic [CH_W-1:0]      b,
        input logic [FRAC_BITS-1:0] f
    );
        logic [LW-1:0] wa;
        logic [LW-1:0] wb;
        logic [LW-1:0] acc;
        wa  = LW'(a) * (LW'(ONE) - LW'(f));
        wb  = LW'(b) * LW'(f);
        acc = wa + wb + LW'(HALF);
        return acc[FRAC_BITS +: CH_W];
    endfunction

    logic                  stall;
    logic                  advance;

    logic                  s1_valid;
    logic                  s1_filter;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic [FRAC_BITS-1:0]  s1_blend_v;
    logic [TEX_W-1:0]      s1_top;
    logic [TEX_W-1:0]      s1_bot;

    logic [TEX_W-1:0]      s1_top_d;
    logic [TEX_W-1:0]      s1_bot_d;
    logic [TEX_W-1:0]      s2_texel_d;

    // Whole pipeline freezes together while the consumer holds off a valid response.
    assign stall     = rsp_valid && !rsp_ready;
    assign advance   = !stall;
    assign req_ready = advance;

    // Horizontal blend of both rows; point mode keeps t0 as the top row.
    always_comb begin
        s1_top_d = req_texels[0];
        s1_bot_d = req_texels[2];
        if (req_filter) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                s1_top_d[c*CH_W +: CH_W] = lerp(req_texels[0][c*CH_W +: CH_W],
                                                req_texels[1][c*CH_W +: CH_W],
                                                req_blend_u);
                s1_bot_d[c*CH_W +: CH_W] = lerp(req_texels[2][c*CH_W +: CH_W],
                                                req_texels[3][c*CH_W +: CH_W],
                                                req_blend_u);
            end
        end
    end

    // Vertical blend between the two row results.
    always_comb begin
        s2_texel_d = s1_top;
        if (s1_filter) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                s2_texel_d[c*CH_W +: CH_W] = lerp(s1_top[c*CH_W +: CH_W],
                                                  s1_bot[c*CH_W +: CH_W],
                                                  s1_blend_v);
            end
        end
    end

    // Valid bits are the only reset state; in-flight work is dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            rsp_valid <= 1'b0;
        end else if (advance) begin
            s1_valid  <= req_valid;
            rsp_valid <= s1_valid;
        end
    end

    // Payload registers, loaded only when their stage actually takes new data.
    always_ff @(posedge clk) begin
        if (advance && req_valid) begin
            s1_filter  <= req_filter;
            s1_tag     <= req_tag;
            s1_blend_v <= req_blend_v;
            s1_top     <= s1_top_d;
            s1_bot     <= s1_bot_d;
        end
        if (advance && s1_valid) begin
            rsp_texel <= s2_texel_d;
            rsp_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_vx_tex_bilerp.sv
// Self-checking bench for vx_tex_bilerp: directed vector table, random streams
// under backpressure against an arithmetic reference model, and reset flushing.
module tb_vx_tex_bilerp;

    localparam int unsigned F  = 8;
    localparam int unsigned TW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_filter;
    logic [3:0][31:0] req_texels;
    logic [F-1:0]     req_blend_u;
    logic [F-1:0]     req_blend_v;
    logic [TW-1:0]    req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_texel;
    logic [TW-1:0]    rsp_tag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             filter;
        logic [3:0][31:0] tex;
        logic [F-1:0]     u;
        logic [F-1:0]     v;
        logic [TW-1:0]    tag;
        logic [31:0]      exp;
        int               issue;
    } vec_t;

    vx_tex_bilerp #(.FRAC_BITS(F), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_filter  (req_filter),
        .req_texels  (req_texels),
        .req_blend_u (req_blend_u),
        .req_blend_v (req_blend_v),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_texel   (rsp_texel),
        .rsp_tag     (rsp_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_lerp(input int a, input int b, input int f);
        return (a * ((1 << F) - f) + b * f + (1 << (F - 1))) >> F;
    endfunction

    function automatic logic [31:0] ref_texel(input logic filt, input logic [3:0][31:0] q,
                                              input int u, input int v);
        logic [31:0] r;
        r = q[0];
        if (filt) begin
            for (int c = 0; c < 4; c++) begin
                int top;
                int bot;
                top = ref_lerp(int'(q[0][c*8 +: 8]), int'(q[1][c*8 +: 8]), u);
                bot = ref_lerp(int'(q[2][c*8 +: 8]), int'(q[3][c*8 +: 8]), u);
                r[c*8 +: 8] = 8'(ref_lerp(top, bot, v));
            end
        end
        return r;
    endfunction

    function automatic vec_t rand_vec(input logic [TW-1:0] tag);
        vec_t t;
        t.filter = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) t.tex[i] = $urandom;
        t.u     = F'($urandom_range(0, (1 << F) - 1));
        t.v     = F'($urandom_range(0, (1 << F) - 1));
        t.tag   = tag;
        t.exp   = ref_texel(t.filter, t.tex, int'(t.u), int'(t.v));
        t.issue = 0;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        req_filter  = t.filter;
        req_texels  = t.tex;
        req_blend_u = t.u;
        req_blend_v = t.v;
        req_tag     = t.tag;
    endtask

    // One isolated request: checks acceptance, 2-cycle latency, data and tag.
    task automatic apply_single(input vec_t t);
        @(negedge clk);
        drive(t);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("single_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("single_latency_early", rsp_valid, 0);
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_texel", rsp_texel, t.exp);
        check("single_tag", rsp_tag, t.tag);
        @(negedge clk);
        check("single_valid_drop", rsp_valid, 0);
    endtask

    // mode 0: rsp_ready always high; 1: random; 2: random with a forced 5-cycle stall.
    task automatic run_stream(input int n, input int mode, input logic [TW-1:0] tag0);
        vec_t        q[$];
        vec_t        cur;
        vec_t        e;
        int          issued = 0;
        int          got = 0;
        int          cyc = 0;
        logic        stalled_prev = 1'b0;
        logic [31:0] ptex = '0;
        logic [TW-1:0] ptag = '0;
        cur = rand_vec(tag0);
        while ((issued < n || q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            if (stalled_prev) begin
                check("stall_valid_held", rsp_valid, 1);
                check("stall_texel_stable", rsp_texel, ptex);
                check("stall_tag_stable", rsp_tag, ptag);
            end
            if (mode == 0) rsp_ready = 1'b1;
            else if (mode == 2 && cyc >= 3 && cyc < 8) rsp_ready = 1'b0;
            else rsp_ready = 1'($urandom_range(0, 1));
            if (issued < n) begin
                drive(cur);
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            check("stream_req_ready", req_ready, !(rsp_valid && !rsp_ready));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra_rsp: got tag %0h expected no response", rsp_tag);
                end else begin
                    e = q.pop_front();
                    check("stream_texel", rsp_texel, e.exp);
                    check("stream_tag", rsp_tag, e.tag);
                    if (mode == 0) check("stream_cadence", cyc, e.issue + 2);
                    got++;
                end
            end
            if (req_valid && req_ready) begin
                cur.issue = cyc;
                q.push_back(cur);
                issued++;
                cur = rand_vec(TW'(tag0 + TW'(issued)));
            end
            stalled_prev = rsp_valid && !rsp_ready;
            ptex = rsp_texel;
            ptag = rsp_tag;
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("stream_issued", issued, n);
        check("stream_received", got, n);
        check("stream_drained", q.size(), 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t t;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        rsp_ready   = 1'b1;
        req_filter  = 1'b0;
        req_texels  = '0;
        req_blend_u = '0;
        req_blend_v = '0;
        req_tag     = '0;

        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_req_ready", req_ready, 1);

        // Directed vector table.
        t = '{filter: 1'b1, tex: '{32'h000000FF, 32'h0, 32'h000000FF, 32'h0},
              u: 8'd128, v: 8'd77, tag: 8'h11, exp: 32'h00000080, issue: 0};
        vecs.push_back(t);
        t = '{filter: 1'b1, tex: '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
              u: 8'd128, v: 8'd128, tag: 8'h22, exp: 32'h40404040, issue: 0};
        vecs.push_back(t);
        t = '{filter: 1'b0, tex: '{$urandom, $urandom, $urandom, 32'h12345678},
              u: 8'd200, v: 8'd33, tag: 8'h33, exp: 32'h12345678, issue: 0};
        vecs.push_back(t);
        for (int i = 0; i < 3; i++) begin
            t = '{filter: 1'b1, tex: '{32'hA5C33C5A, 32'hA5C33C5A, 32'hA5C33C5A, 32'hA5C33C5A},
                  u: 8'($urandom), v: 8'($urandom), tag: 8'(8'h40 + i), exp: 32'hA5C33C5A, issue: 0};
            vecs.push_back(t);
        end
        for (int i = 0; i < 3; i++) begin
            t = rand_vec(8'(8'h50 + i));
            t.filter = 1'b1;
            t.u = '0;
            t.v = '0;
            t.exp = t.tex[0];
            vecs.push_back(t);
        end
        t = '{filter: 1'b1, tex: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0},
              u: 8'd0, v: 8'd255, tag: 8'h60, exp: 32'hFEFEFEFE, issue: 0};
        vecs.push_back(t);
        for (int i = 0; i < 10; i++) vecs.push_back(rand_vec(8'(8'h70 + i)));

        foreach (vecs[i]) apply_single(vecs[i]);

        // Streams: full rate, random backpressure, forced stall with pipeline full.
        run_stream(8, 0, 8'h80);
        run_stream(8, 2, 8'h90);
        run_stream(40, 1, 8'hA0);

        // Reset with a full, stalled pipeline discards everything in flight.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(rand_vec(8'hC0));
        req_valid = 1'b1;
        @(negedge clk);
        drive(rand_vec(8'hC1));
        @(negedge clk);
        req_valid = 1'b0;
        check("full_before_reset", rsp_valid, 1);
        check("stalled_req_ready", req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_rsp", rsp_valid, 0);
        end
        apply_single(rand_vec(8'hD0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_tex_bilerp.md
Name: VX_tex_bilerp

Overview:
- Bilinear filter stage directly downstream of the texel format converter.
- Consumes a 2x2 quad of texels already expanded to A8R8G8B8 plus fractional U/V weights.
- Produces one filtered A8R8G8B8 texel per request through a 2-stage valid/ready pipeline.
- Also supports point sampling, which passes texel 0 through unchanged.

Parameters:
- FRAC_BITS, 8, width of the blend_u/blend_v fractional weights (legal 1..8).
- TAG_WIDTH, 8, width of the opaque request tag carried alongside the data.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  input quad valid.
- req_ready  out  1  stage can accept input this cycle.
- req_filter  in  1  0 = point, 1 = bilinear.
- req_texels  in  4x32  quad {t3,t2,t1,t0}: t0=(u0,v0), t1=(u1,v0), t2=(u0,v1), t3=(u1,v1).
- req_blend_u  in  FRAC_BITS  horizontal weight toward t1/t3.
- req_blend_v  in  FRAC_BITS  vertical weight toward the bottom row.
- req_tag  in  TAG_WIDTH  request tag.
- rsp_valid  out  1  filtered texel valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_texel  out  32  filtered A8R8G8B8 texel.
- rsp_tag  out  TAG_WIDTH  tag of the response.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset low asynchronously clears both stage valid bits; rsp_valid=0 during and immediately after reset.
  - Data and tag registers need not be reset; rsp_texel and rsp_tag are don't-care while rsp_valid=0.
  - Reset asserted mid-operation discards all in-flight requests. No response for them is produced after reset release.
- Handshake:
  - Input transfer occurs when req_valid && req_ready.
  - Output transfer occurs when rsp_valid && rsp_ready.
  - stall = rsp_valid && !rsp_ready; req_ready = !stall, combinational.
  - While stalled, both stages hold their contents and rsp_* are stable.
  - Bubbles are not collapsed: the whole pipeline freezes together.
- Latency and throughput:
  - Latency is 2 cycles from input accept to rsp_valid.
  - With rsp_ready held high, throughput is one request per cycle.
- Stage 1: latch filter, tag, blend_v and the bottom-row t2/t3 data. Per channel c of 4 (8 bits each):
  - top_c = lerp(t0_c, t1_c, u)
  - bot_c = lerp(t2_c, t3_c, u)
  - In point mode: top = t0, and bot and blend_v are ignored.
- Stage 2:
  - Bilinear: out_c = lerp(top_c, bot_c, v).
  - Point: out = top, which equals t0 bit-exact.
  - Register out_c into rsp_texel together with the tag.
- Arithmetic:
  - lerp(a,b,f) = (a*(2^F - f) + b*f + 2^(F-1)) >> F, with F = FRAC_BITS.
  - Intermediate width is 8+F+1 bits, unsigned.
  - Result is always within [min(a,b), max(a,b)]; no clamping is needed.
  - f=0 yields exactly a. a=b yields exactly a for every f.
  - No extrapolation: f is never 2^F.
- Channels are independent; no cross-channel carries.
- Simultaneous events: when the output fires and a new input is accepted in the same cycle, both stages advance normally.

Test Plan:
- Reset with pipeline full → rsp_valid=0 immediately and stays 0 after release until new inputs; no stale responses appear.
- Bilinear: t0=0, t1=0x000000FF, t2=0, t3=0x000000FF, u=128, v=77 → rsp_texel=0x00000080, two cycles after accept, tag preserved.
- Bilinear: t0=t1=t2=0, t3=0xFFFFFFFF, u=128, v=128 → rsp_texel=0x40404040.
- Point mode: t0=0x12345678, other texels random, u=200, v=33 → rsp_texel=0x12345678.
- Identity: all four texels 0xA5C33C5A, random u/v → rsp_texel=0xA5C33C5A. Also u=v=0 with random quad → t0.
- Backpressure:
  - Stream 8 tagged requests back-to-back while rsp_ready toggles randomly, including 5 low cycles with the pipeline full.
  - Required: req_ready=0 exactly while stalled, outputs stable during stall, all 8 responses in order, no drops or duplicates.
  - With rsp_ready=1 throughout, one response per cycle.
